fp_div_iter: RTL and testbench
==============================

Name: fp_div_iter

Overview:
- Multi-cycle FDIV.S unit in the F-extension execute path.
- Consumes the two single-precision operands read from the FP register file (RD1 = dividend, RD2 = divisor) and returns the quotient as the FP register-file write-back (result → WD3, rd_out → A3, done → WE3).
- Holds `busy` high while computing so the core stalls its PC and other write-backs.
- Radix-2 restoring division, one quotient bit per cycle, round-to-nearest-even only.

Parameters:
- QBITS, 26, quotient bits generated: 1 integer, 23 fraction, guard, round. Not intended to be changed.
- EXP_W, 10, signed internal exponent width. Covers underflow and overflow range without wrap.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op_a  in  32  dividend, IEEE-754 binary32
- op_b  in  32  divisor, IEEE-754 binary32
- rd_in  in  5  destination FP register index, latched with the operands
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; result valid; drives WE3
- result  out  32  quotient; drives WD3
- rd_out  out  5  latched rd_in; drives A3
- fflags  out  5  {NV, DZ, OF, UF, NX}, valid with done

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE.
  - busy, done, result, rd_out, fflags all go to 0.
  - The datapath is cleared; the pending write-back is lost.
- States: IDLE → UNPACK → DIVIDE → ROUND → DONE → IDLE. UNPACK → DONE directly for special operands.
- IDLE:
  - On `start` = 1 at edge N: latch op_a, op_b and rd_in; go to UNPACK.
  - `start` while busy = 1 (including the DONE cycle) is ignored, with no queueing.
- UNPACK (cycle N+1):
  - Classify both operands (zero, subnormal, normal, inf, qNaN, sNaN) and compute sign = sa ^ sb.
  - Subnormal inputs are normalized via a leading-zero count; the hidden bit becomes 1 and the exponent is adjusted (may go below 1).
  - exp = ea − eb + 127, EXP_W signed.
  - If mant_a < mant_b: dividend shifted left 1 and exp −= 1, so the quotient lies in [1,2).
- Special cases go to DONE in the next cycle:
  - Either operand NaN → 0x7FC00000; NV set if either is sNaN.
  - 0/0 or inf/inf → 0x7FC00000, NV.
  - Finite nonzero / 0 → ±inf (0x7F800000 | sign<<31), DZ.
  - inf / finite → ±inf, no flags.
  - 0 / nonzero, or finite / inf → ±0, no flags.
- DIVIDE (cycles N+2 .. N+27, exactly QBITS cycles):
  - Each cycle: trial-subtract the 25-bit divisor from the partial remainder. If nonnegative, the quotient bit is 1 and the remainder is replaced; otherwise the bit is 0. Then shift the remainder left 1.
  - A down-counter from QBITS−1 ends the state at 0.
  - sticky = (final remainder ≠ 0).
- ROUND (cycle N+28):
  - RNE on guard, round and sticky: increment if g & (r | s | lsb).
  - Mantissa carry-out → mantissa = 1.0, exp += 1.
  - exp ≥ 255 → ±inf, OF | NX.
  - exp ≤ 0 → flush to signed zero, UF | NX. This is a decided deviation: no subnormal results.
  - Otherwise NX = g | r | s.
- DONE (cycle N+29 normal, N+2 special):
  - done = 1 for exactly one cycle.
  - result, rd_out and fflags are valid here and held until the next accepted start.

Decomposition:
- Package fp32_pkg:
  - constants BIAS = 127, EXP_MAX = 255, CANON_NAN = 0x7FC00000, POS_INF = 0x7F800000
  - fflags bit indices (NV = 4, DZ = 3, OF = 2, UF = 1, NX = 0)
  - FSM state encoding
  - operand-class enum; shared with the later FP add and FP multiply units
- Sub-module fp32_unpack (combinational, reusable): class flags, sign, unbiased exponent, normalized 24-bit mantissa via leading-zero count.

Test Plan:
- 6.0/2.0: op_a = 0x40C00000, op_b = 0x40000000, start at edge N → busy high N+1..N+29; done pulse at N+29; result = 0x40400000; fflags = 0; rd_out = rd_in (e.g. 5'd7).
- 1.0/3.0: 0x3F800000 / 0x40400000 → result = 0x3EAAAAAB, fflags = NX (0x01).
- Specials, each with done at N+2:
  - 0x3F800000 / 0x00000000 → 0x7F800000, DZ (0x08).
  - 0x00000000 / 0x00000000 → 0x7FC00000, NV (0x10).
  - 0x7F800001 (sNaN) / 0x3F800000 → 0x7FC00000, NV.
- Overflow and underflow:
  - 0x7F7FFFFF / 0x3F000000 → 0x7F800000, OF|NX (0x05).
  - 0x00800000 / 0x40000000 → 0x00000000, UF|NX (0x03).
  - Subnormal input 0x00400000 / 0x00400000 → 0x3F800000, fflags 0.
- Busy / reset:
  - Second start at N+5 with different operands is ignored; the first result is returned unchanged.
  - RST low at N+10 → busy, done, result all 0 immediately; no done pulse follows.
  - A new start after reset release completes normally with 29-cycle latency.

Source files
------------

// File: rtl/fp32_pkg.sv
// Binary32 constants, operand classes and FDIV control encodings.
// Shared with the FP add and multiply units.
package fp32_pkg;

   localparam int unsigned QBITS   = 26;
   localparam int unsigned EXP_W   = 10;
   localparam int unsigned MANT_W  = 24;
   localparam int unsigned BIAS    = 127;
   localparam int unsigned EXP_MAX = 255;

   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF   = 32'h7F80_0000;

   localparam int unsigned FL_NV = 4;
   localparam int unsigned FL_DZ = 3;
   localparam int unsigned FL_OF = 2;
   localparam int unsigned FL_UF = 1;
   localparam int unsigned FL_NX = 0;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_UNPACK = 3'd1;
   localparam logic [2:0] S_DIVIDE = 3'd2;
   localparam logic [2:0] S_ROUND  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_SUB,
      CLS_NORM,
      CLS_INF,
      CLS_QNAN,
      CLS_SNAN
   } fp_class_e;

   // exp is unbiased two's complement; mant always has its leading 1 at the top unless zero
   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
      fp_class_e         cls;
   } fp_unpacked_t;

endpackage

// File: rtl/fp_div_iter_if.sv
// Request / write-back bundle between the FP execute stage and the divider.
interface fp_div_iter_if;
   logic        start;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic [4:0]  fflags;

   modport master (output start, op_a, op_b, rd_in,
                   input  busy, done, result, rd_out, fflags);
   modport slave  (input  start, op_a, op_b, rd_in,
                   output busy, done, result, rd_out, fflags);
endinterface

// File: rtl/fp32_unpack.sv
// Combinational binary32 classifier; subnormals come out normalized with an extended exponent.
module fp32_unpack
   import fp32_pkg::*;
(
   input  logic [31:0]  x,
   output fp_unpacked_t u
);
   logic [7:0]        e;
   logic [22:0]       f;
   logic [MANT_W-1:0] m0;
   logic [4:0]        lz;

   assign e  = x[30:23];
   assign f  = x[22:0];
   assign m0 = {1'b0, f};

   // leading-zero count of the subnormal significand
   always_comb begin
      lz = '0;
      for (int i = 0; i < MANT_W; i++)
         if (m0[i]) lz = 5'(MANT_W - 1 - i);
   end

   always_comb begin
      u.sign = x[31];
      u.exp  = EXP_W'(e) - EXP_W'(BIAS);
      u.mant = {1'b1, f};
      u.cls  = CLS_NORM;
      if (e == 8'hFF) begin
         if (f == '0)   u.cls = CLS_INF;
         else if (f[22]) u.cls = CLS_QNAN;
         else           u.cls = CLS_SNAN;
      end else if (e == 8'h00) begin
         if (f == '0) begin
            u.cls  = CLS_ZERO;
            u.exp  = '0;
            u.mant = '0;
         end else begin
            u.cls  = CLS_SUB;
            u.exp  = EXP_W'(1) - EXP_W'(BIAS) - EXP_W'(lz);
            u.mant = m0 << lz;
         end
      end
   end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative FDIV.S: radix-2 restoring divide, one quotient bit per cycle, RNE rounding,
// underflowing results flush to signed zero.
module fp_div_iter
   import fp32_pkg::*;
(
   input  logic         CLK,
   input  logic         RST,
   fp_div_iter_if.slave bus
);
   localparam int unsigned REM_W = MANT_W + 2;
   localparam int unsigned CNT_W = $clog2(QBITS);

   logic [2:0]        state, state_nxt;
   logic [31:0]       opa_q, opb_q;
   logic [4:0]        rd_q;
   logic              sign_q;
   logic [EXP_W-1:0]  exp_q;
   logic [MANT_W-1:0] div_q;
   logic [REM_W-1:0]  rem_q;
   logic [QBITS-2:0]  quo_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q, done_q;
   logic [31:0]       result_q;
   logic [4:0]        rd_out_q, fflags_q;

   fp_unpacked_t ua, ub;

   fp32_unpack u_unpack_a (.x(opa_q), .u(ua));
   fp32_unpack u_unpack_b (.x(opb_q), .u(ub));

   logic             sign_c, a_lt_b;
   logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, special_c;
   logic [EXP_W-1:0] exp_c;
   logic [31:0]      spec_res;
   logic [4:0]       spec_flags;

   assign sign_c    = ua.sign ^ ub.sign;
   assign a_snan    = (ua.cls == CLS_SNAN);
   assign b_snan    = (ub.cls == CLS_SNAN);
   assign a_nan     = a_snan || (ua.cls == CLS_QNAN);
   assign b_nan     = b_snan || (ub.cls == CLS_QNAN);
   assign a_inf     = (ua.cls == CLS_INF);
   assign b_inf     = (ub.cls == CLS_INF);
   assign a_zero    = (ua.cls == CLS_ZERO);
   assign b_zero    = (ub.cls == CLS_ZERO);
   assign special_c = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
   assign a_lt_b    = (ua.mant < ub.mant);
   assign exp_c     = ua.exp - ub.exp + EXP_W'(BIAS) - EXP_W'(a_lt_b);

   // special-operand results, highest priority first
   always_comb begin
      spec_res   = {sign_c, 31'd0};
      spec_flags = '0;
      if (a_nan || b_nan) begin
         spec_res          = CANON_NAN;
         spec_flags[FL_NV] = a_snan | b_snan;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_res          = CANON_NAN;
         spec_flags[FL_NV] = 1'b1;
      end else if (a_inf) begin
         spec_res = POS_INF | {sign_c, 31'd0};
      end else if (b_inf) begin
         spec_res = {sign_c, 31'd0};
      end else if (b_zero) begin
         spec_res          = POS_INF | {sign_c, 31'd0};
         spec_flags[FL_DZ] = 1'b1;
      end
   end

   logic [REM_W:0] diff;
   logic           qbit;

   assign diff = {1'b0, rem_q} - {3'b000, div_q};
   assign qbit = ~diff[REM_W];

   // the always-1 integer quotient bit has shifted out; quo_q holds fraction, guard, round
   logic             g, r, s, inc;
   logic [23:0]      sum;
   logic [EXP_W-1:0] exp_r;
   logic [31:0]      rnd_res;
   logic [4:0]       rnd_flags;

   always_comb begin
      g     = quo_q[1];
      r     = quo_q[0];
      s     = |rem_q;
      inc   = g & (r | s | quo_q[2]);
      sum   = {1'b0, quo_q[QBITS-2:2]} + {23'd0, inc};
      exp_r = exp_q + EXP_W'(sum[23]);
      rnd_res          = {sign_q, exp_r[7:0], sum[22:0]};
      rnd_flags        = '0;
      rnd_flags[FL_NX] = g | r | s;
      if (!exp_r[EXP_W-1] && (exp_r >= EXP_W'(EXP_MAX))) begin
         rnd_res          = POS_INF | {sign_q, 31'd0};
         rnd_flags[FL_OF] = 1'b1;
         rnd_flags[FL_NX] = 1'b1;
      end else if (exp_r[EXP_W-1] || (exp_r == '0)) begin
         rnd_res          = {sign_q, 31'd0};
         rnd_flags[FL_UF] = 1'b1;
         rnd_flags[FL_NX] = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (bus.start) state_nxt = S_UNPACK;
         S_UNPACK: state_nxt = special_c ? S_DONE : S_DIVIDE;
         S_DIVIDE: if (cnt_q == '0) state_nxt = S_ROUND;
         S_ROUND:  state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // operand latch and divide datapath
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         opa_q  <= '0;
         opb_q  <= '0;
         rd_q   <= '0;
         sign_q <= 1'b0;
         exp_q  <= '0;
         div_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.start) begin
               opa_q <= bus.op_a;
               opb_q <= bus.op_b;
               rd_q  <= bus.rd_in;
            end
            S_UNPACK: begin
               sign_q <= sign_c;
               exp_q  <= exp_c;
               div_q  <= ub.mant;
               rem_q  <= a_lt_b ? {1'b0, ua.mant, 1'b0} : {2'b00, ua.mant};
               quo_q  <= '0;
               cnt_q  <= CNT_W'(QBITS - 1);
            end
            S_DIVIDE: begin
               rem_q <= (qbit ? diff[REM_W-1:0] : rem_q) << 1;
               quo_q <= {quo_q[QBITS-3:0], qbit};
               cnt_q <= cnt_q - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // write-back registers; result fields are held until the next operation completes
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
         fflags_q <= '0;
      end else begin
         busy_q <= (state_nxt != S_IDLE);
         done_q <= (state_nxt == S_DONE);
         if ((state == S_UNPACK) && special_c) begin
            result_q <= spec_res;
            fflags_q <= spec_flags;
            rd_out_q <= rd_q;
         end else if (state == S_ROUND) begin
            result_q <= rnd_res;
            fflags_q <= rnd_flags;
            rd_out_q <= rd_q;
         end
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.rd_out = rd_out_q;
   assign bus.fflags = fflags_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: arithmetic, specials, range limits, busy and reset behaviour.
module tb_fp_div_iter;
   logic CLK = 1'b0;
   logic RST;

   always #5 CLK = ~CLK;

   fp_div_iter_if bus ();

   fp_div_iter dut (.CLK(CLK), .RST(RST), .bus(bus));

   typedef struct {
      logic [31:0] res;
      logic [4:0]  fl;
      logic [4:0]  rd;
      int          lat;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [4:0]  fl;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] res, input logic [4:0] fl, input int lat);
      exp_t e;
      @(negedge CLK);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      bus.rd_in = rd;
      e.res = res;
      e.fl  = fl;
      e.rd  = rd;
      e.lat = lat;
      sb.push_back(e);
      @(negedge CLK);
      bus.start = 1'b0;
      bus.op_a  = $urandom;
      bus.op_b  = $urandom;
      bus.rd_in = 5'($urandom);
   endtask

   // lat counts cycles after the accepting edge; entry is the first negedge after it
   task automatic wait_done(output int lat, output bit busy_ok, output bit timed_out);
      lat = 1;
      busy_ok = 1'b1;
      timed_out = 1'b0;
      while (bus.done !== 1'b1) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (lat >= 60) begin
            timed_out = 1'b1;
            return;
         end
         @(negedge CLK);
         lat++;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      #2 RST = 1'b0;
      repeat (3) @(negedge CLK);
      checks += 2;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset busy/done got %b/%b want 0/0", bus.busy, bus.done);
      end
      if (bus.result !== 32'h0 || bus.rd_out !== 5'h0 || bus.fflags !== 5'h0) begin
         errors++;
         $display("FAIL reset outputs got %08h/%0d/%02h want 0/0/0", bus.result, bus.rd_out, bus.fflags);
      end
      RST = 1'b1;
      @(negedge CLK);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release busy got %b want 0", bus.busy);
      end
   endtask

   task automatic test_arith();
      vec_t v[6];
      exp_t e;
      int lat;
      bit bok, to;
      v[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'h00};
      v[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01};
      v[2] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 5'h00};
      v[3] = '{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 5'h01};
      v[4] = '{32'h40400000, 32'h40000000, 32'h3FC00000, 5'h00};
      v[5] = '{32'h3F7FFFFF, 32'h3F800001, 32'h3F7FFFFD, 5'h01};
      for (int i = 0; i < 6; i++) begin
         drive_op(v[i].a, v[i].b, 5'(7 + i), v[i].res, v[i].fl, 29);
         wait_done(lat, bok, to);
         e = sb.pop_front();
         checks += 5;
         if (to) begin
            errors += 5;
            $display("FAIL arith[%0d] no done within 60 cycles", i);
         end else begin
            if (bus.result !== e.res) begin
               errors++;
               $display("FAIL arith[%0d] result got %08h want %08h", i, bus.result, e.res);
            end
            if (bus.fflags !== e.fl) begin
               errors++;
               $display("FAIL arith[%0d] fflags got %02h want %02h", i, bus.fflags, e.fl);
            end
            if (bus.rd_out !== e.rd) begin
               errors++;
               $display("FAIL arith[%0d] rd_out got %0d want %0d", i, bus.rd_out, e.rd);
            end
            if (lat != e.lat || !bok) begin
               errors++;
               $display("FAIL arith[%0d] latency got %0d busy_held %0b want %0d 1", i, lat, bok, e.lat);
            end
            @(negedge CLK);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== e.res) begin
               errors++;
               $display("FAIL arith[%0d] after done got done %b busy %b result %08h want 0 0 %08h",
                        i, bus.done, bus.busy, bus.result, e.res);
            end
         end
      end
   endtask

   task automatic test_specials();
      vec_t v[10];
      exp_t e;
      int lat;
      bit bok, to;
      v[0] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08};
      v[1] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10};
      v[2] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10};
      v[3] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'h00};
      v[4] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'h10};
      v[5] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 5'h00};
      v[6] = '{32'h80000000, 32'h3F800000, 32'h80000000, 5'h00};
      v[7] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 5'h00};
      v[8] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 5'h08};
      v[9] = '{32'h3F800000, 32'h7F800001, 32'h7FC00000, 5'h10};
      for (int i = 0; i < 10; i++) begin
         drive_op(v[i].a, v[i].b, 5'(20 + i), v[i].res, v[i].fl, 2);
         wait_done(lat, bok, to);
         e = sb.pop_front();
         checks += 4;
         if (to) begin
            errors += 4;
            $display("FAIL special[%0d] no done within 60 cycles", i);
         end else begin
            if (bus.result !== e.res) begin
               errors++;
               $display("FAIL special[%0d] result got %08h want %08h", i, bus.result, e.res);
            end
            if (bus.fflags !== e.fl) begin
               errors++;
               $display("FAIL special[%0d] fflags got %02h want %02h", i, bus.fflags, e.fl);
            end
            if (bus.rd_out !== e.rd) begin
               errors++;
               $display("FAIL special[%0d] rd_out got %0d want %0d", i, bus.rd_out, e.rd);
            end
            if (lat != e.lat || !bok) begin
               errors++;
               $display("FAIL special[%0d] latency got %0d busy_held %0b want %0d 1", i, lat, bok, e.lat);
            end
            @(negedge CLK);
         end
      end
   endtask

   task automatic test_range();
      vec_t v[7];
      exp_t e;
      int lat;
      bit bok, to;
      v[0] = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'h05};
      v[1] = '{32'h00800000, 32'h40000000, 32'h00000000, 5'h03};
      v[2] = '{32'h00400000, 32'h00400000, 32'h3F800000, 5'h00};
      v[3] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 5'h00};
      v[4] = '{32'h01000000, 32'h40000000, 32'h00800000, 5'h00};
      v[5] = '{32'hFF7FFFFF, 32'h3F000000, 32'hFF800000, 5'h05};
      v[6] = '{32'h80800000, 32'h40000000, 32'h80000000, 5'h03};
      for (int i = 0; i < 7; i++) begin
         drive_op(v[i].a, v[i].b, 5'(2 + i), v[i].res, v[i].fl, 29);
         wait_done(lat, bok, to);
         e = sb.pop_front();
         checks += 3;
         if (to) begin
            errors += 3;
            $display("FAIL range[%0d] no done within 60 cycles", i);
         end else begin
            if (bus.result !== e.res) begin
               errors++;
               $display("FAIL range[%0d] result got %08h want %08h", i, bus.result, e.res);
            end
            if (bus.fflags !== e.fl) begin
               errors++;
               $display("FAIL range[%0d] fflags got %02h want %02h", i, bus.fflags, e.fl);
            end
            if (lat != e.lat || !bok) begin
               errors++;
               $display("FAIL range[%0d] latency got %0d busy_held %0b want %0d 1", i, lat, bok, e.lat);
            end
            @(negedge CLK);
         end
      end
   endtask

   task automatic test_busy_ignore();
      exp_t e;
      int lat;
      bit seen;
      drive_op(32'h40C00000, 32'h40000000, 5'd7, 32'h40400000, 5'h00, 29);
      lat = 1;
      while (bus.done !== 1'b1 && lat < 60) begin
         if (lat == 5) begin
            bus.start = 1'b1;
            bus.op_a  = 32'h3F800000;
            bus.op_b  = 32'h40400000;
            bus.rd_in = 5'd9;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge CLK);
         lat++;
      end
      e = sb.pop_front();
      checks += 3;
      if (bus.done !== 1'b1 || lat != e.lat) begin
         errors++;
         $display("FAIL busy_ignore done %b at %0d want 1 at %0d", bus.done, lat, e.lat);
      end
      if (bus.result !== e.res || bus.fflags !== e.fl) begin
         errors++;
         $display("FAIL busy_ignore result %08h/%02h want %08h/%02h", bus.result, bus.fflags, e.res, e.fl);
      end
      if (bus.rd_out !== e.rd) begin
         errors++;
         $display("FAIL busy_ignore rd_out got %0d want %0d", bus.rd_out, e.rd);
      end
      // a start presented during the DONE cycle must also be dropped
      bus.start = 1'b1;
      bus.op_a  = 32'h3F800000;
      bus.op_b  = 32'h40400000;
      bus.rd_in = 5'd9;
      @(negedge CLK);
      bus.start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 35; k++) begin
         if (bus.busy === 1'b1 || bus.done === 1'b1) seen = 1'b1;
         @(negedge CLK);
      end
      checks++;
      if (seen || bus.result !== e.res) begin
         errors++;
         $display("FAIL busy_ignore_done_start activity %0b result %08h want 0 %08h", seen, bus.result, e.res);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      drive_op(32'h3F800000, 32'h40400000, 5'd12, 32'h3EAAAAAB, 5'h01, 29);
      repeat (9) @(negedge CLK);
      RST = 1'b0;
      #1;
      sb.delete();
      checks += 3;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid busy/done got %b/%b want 0/0", bus.busy, bus.done);
      end
      if (bus.result !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid result got %08h want 00000000", bus.result);
      end
      if (bus.fflags !== 5'h0 || bus.rd_out !== 5'h0) begin
         errors++;
         $display("FAIL reset_mid fflags/rd_out got %02h/%0d want 0/0", bus.fflags, bus.rd_out);
      end
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.busy === 1'b1 || bus.done === 1'b1) seen = 1'b1;
         @(negedge CLK);
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_mid lost op still active got 1 want 0");
      end
   endtask

   task automatic test_after_reset();
      exp_t e;
      int lat;
      bit bok, to;
      drive_op(32'h40C00000, 32'h40000000, 5'd7, 32'h40400000, 5'h00, 29);
      wait_done(lat, bok, to);
      e = sb.pop_front();
      checks += 3;
      if (to || bus.result !== e.res || bus.fflags !== e.fl) begin
         errors++;
         $display("FAIL after_reset result got %08h/%02h want %08h/%02h", bus.result, bus.fflags, e.res, e.fl);
      end
      if (bus.rd_out !== e.rd) begin
         errors++;
         $display("FAIL after_reset rd_out got %0d want %0d", bus.rd_out, e.rd);
      end
      if (to || lat != e.lat || !bok) begin
         errors++;
         $display("FAIL after_reset latency got %0d busy_held %0b want %0d 1", lat, bok, e.lat);
      end
      @(negedge CLK);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      bus.rd_in = '0;
      test_reset();
      test_arith();
      test_specials();
      test_busy_ignore();
      test_range();
      test_reset_mid();
      test_after_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
